mpc_rob: RTL
============

Name: mpc_rob

Overview:
- Per-channel read reorder buffer for the MPC.
- Allocates a rob_id for each load the channel issues toward the banks.
- Accepts out-of-order rc_rsp_t read returns from the banks and presents them to the channel as channel_rsp_t, strictly in allocation order.
- Sits between the bank response crossbar and one channel's response port; one instance per channel.

Parameters:
- ROB_SIZE, 8, number of entries; power of two, 2..8 (rob_id field is 3 bits).
- CHANNEL_ID, 0, 2-bit channel number this instance serves; responses with another channel_id are ignored.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- alloc_valid_i  input  1  channel requests a rob_id for an outgoing load.
- alloc_ready_o  output  1  entry available.
- alloc_id_o  output  3  rob_id granted on an alloc handshake (= tail pointer).
- rsp_valid_i  input  1  bank response valid; always accepted, no ready.
- rsp_i  input  133  rc_rsp_t {channel_id[1:0], rob_id[2:0], rdata[127:0]}.
- out_valid_o  output  1  in-order response available to the channel.
- out_ready_i  input  1  channel accepts the response.
- out_rsp_o  output  128  channel_rsp_t.rdata of the head entry.
- count_o  output  4  number of allocated entries, 0..ROB_SIZE.
- err_o  output  1  one-cycle pulse on an illegal response.

Behaviour:
- State
  - head and tail pointers, log2(ROB_SIZE) bits, wrap modulo ROB_SIZE.
  - count register.
  - per-entry alloc and filled bits.
  - data array, 128 b per entry, not reset.
- Reset, synchronous, highest priority:
  - head=0, tail=0, count=0, all alloc and filled bits=0.
  - Outputs: alloc_ready_o=1, alloc_id_o=0, out_valid_o=0, err_o=0, count_o=0.
  - out_rsp_o is don't-care while out_valid_o=0.
  - Reset mid-operation discards all entries; responses arriving in the reset cycle are dropped.
- Allocate
  - alloc_ready_o = (count < ROB_SIZE). It is a function of registered count only; no combinational path from out_ready_i.
  - On alloc_valid_i & alloc_ready_o: alloc[tail]=1, filled[tail]=0, tail++.
  - alloc_id_o always equals tail.
- Fill
  - Applies only on rsp_valid_i & channel_id==CHANNEL_ID.
  - Index = rob_id[log2(ROB_SIZE)-1:0].
  - If alloc[idx]=1 and filled[idx]=0: write rdata, filled[idx]=1.
  - Otherwise drop the data, leave state unchanged, and set err_o=1 in the next cycle for exactly one cycle. This covers rob_id >= ROB_SIZE, an unallocated entry, and a double fill.
  - A fill targeting the entry allocated in the same cycle counts as unallocated, so it is an error.
- Release
  - out_valid_o = alloc[head] & filled[head], from registers.
  - out_rsp_o = data[head].
  - On out_valid_o & out_ready_i: alloc[head]=0, filled[head]=0, head++.
- Latency
  - A fill in cycle N makes out_valid_o visible at N+1 at the earliest. No fill-to-output bypass.
  - Minimum alloc-to-release is 2 cycles.
- Stability: while out_valid_o=1 and out_ready_i=0, out_valid_o and out_rsp_o hold. A later fill of a non-head entry does not disturb the head.
- count_o update: count +1 on alloc only, -1 on release only, unchanged on both or neither.
- Full: with count=ROB_SIZE, alloc_ready_o=0 even if a release occurs in the same cycle; it rises the cycle after the release.
- Empty: out_valid_o=0 and any response is an error.
- Simultaneous events:
  - Alloc, fill of another entry, and release of head are all legal in one cycle.
  - Fill and release never target the same entry in one cycle, because release requires filled.
- Responses never back-pressure the banks. Flow control is guaranteed by allocation before issue.

Test Plan:
- In-order: alloc 3 (ids 0,1,2), fill 0,1,2 with data A,B,C, out_ready_i=1 -> out_rsp_o A,B,C on consecutive cycles; count_o returns to 0.
- Out-of-order: alloc 4, fill ids 2,0,3,1 -> no output until id0 is filled; then order 0,1,2,3 with out_valid_o first high the cycle after the id0 fill.
- Full/wrap: alloc 8 -> alloc_ready_o=0, count_o=8. Fill all, release 1 with alloc_valid_i held -> alloc_ready_o=1 one cycle later, alloc_id_o=0. Run 20 cycles of mixed traffic to check pointer wrap.
- Backpressure: head filled, out_ready_i=0 for 5 cycles while other entries are filled -> out_valid_o=1 and out_rsp_o stable for all 5 cycles.
- Filtering/errors, all with state unchanged:
  - channel_id != CHANNEL_ID -> no state change, err_o=0.
  - Fill of an unallocated id -> err_o pulses 1 cycle.
  - Double fill of id 1 -> err_o pulse, original data retained.
- Reset mid-operation: 5 allocated, 3 filled, assert rst_i one cycle -> out_valid_o=0, count_o=0, alloc_id_o=0, alloc_ready_o=1 next cycle; a late fill of id 2 -> err_o pulse.

Source files
------------

// File: rtl/mpc_rob.sv
// Per-channel read reorder buffer: hands out rob_ids in order, absorbs
// out-of-order bank read returns, and releases them to the channel in
// allocation order.
module mpc_rob #(
  parameter int         ROB_SIZE   = 8,
  parameter logic [1:0] CHANNEL_ID = 2'd0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         alloc_valid_i,
  output logic         alloc_ready_o,
  output logic [2:0]   alloc_id_o,
  input  logic         rsp_valid_i,
  input  logic [132:0] rsp_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_rsp_o,
  output logic [3:0]   count_o,
  output logic         err_o
);
  localparam int IW = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

  logic [IW-1:0]       head;
  logic [IW-1:0]       tail;
  logic [3:0]          count;
  logic [ROB_SIZE-1:0] alloc_q;
  logic [ROB_SIZE-1:0] filled_q;
  logic [127:0]        data_q [ROB_SIZE];
  logic                err_q;

  logic [1:0]   rsp_ch;
  logic [2:0]   rsp_id;
  logic [127:0] rsp_data;
  logic [IW-1:0] idx;
  logic hit;
  logic in_range;
  logic fill_ok;
  logic do_alloc;
  logic do_release;

  assign rsp_ch   = rsp_i[132:131];
  assign rsp_id   = rsp_i[130:128];
  assign rsp_data = rsp_i[127:0];
  assign idx      = rsp_id[IW-1:0];

  // A fill is legal only into an entry allocated in an earlier cycle and
  // not yet filled; alloc_q is registered, so the entry being allocated
  // this cycle still reads as unallocated.
  assign hit      = rsp_valid_i && (rsp_ch == CHANNEL_ID);
  assign in_range = (32'(rsp_id) < ROB_SIZE);
  assign fill_ok  = hit && in_range && alloc_q[idx] && !filled_q[idx];

  // Ready depends only on the registered count, so a release does not
  // reopen allocation until the following cycle.
  assign alloc_ready_o = (count < 4'(ROB_SIZE));
  assign alloc_id_o    = 3'(tail);
  assign do_alloc      = alloc_valid_i && alloc_ready_o;

  assign out_valid_o = alloc_q[head] && filled_q[head];
  assign out_rsp_o   = data_q[head];
  assign do_release  = out_valid_o && out_ready_i;

  assign count_o = count;
  assign err_o   = err_q;

  // Pointer, occupancy, entry-status and error-pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      alloc_q  <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (do_alloc) begin
        alloc_q[tail]  <= 1'b1;
        filled_q[tail] <= 1'b0;
        tail           <= tail + 1'b1;
      end
      if (do_release) begin
        alloc_q[head]  <= 1'b0;
        filled_q[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (fill_ok) begin
        filled_q[idx] <= 1'b1;
      end
      err_q <= hit && !fill_ok;
      case ({do_alloc, do_release})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; no reset needed since filled_q gates its visibility.
  always_ff @(posedge clk_i) begin
    if (fill_ok && !rst_i) begin
      data_q[idx] <= rsp_data;
    end
  end

endmodule
